inst_encoder: RTL and testbench
===============================

INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter ADDR_W, default 8, sets the instruction-memory address width; depth is 2^ADDR_W words.
REQ-002 clk  input  1  single clock; all logic on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle pulse that begins a program load.
REQ-005 in_valid, in_ready  input/output  1 each  instruction-field handshake; a transfer happens when both are 1 on a clock edge.
REQ-006 op  input  5  operation code: 0 NOP, 1 HALT, 2 LB, 3 SB, 4 ADDI, 5 ANDI, 6 ORI, 7 ADD, 8 SUB, 9 SRA, 10 SRL, 11 SLL, 12 AND, 13 OR, 14 BEQ, 15 BNE, 16 BGEZ, 17 BLTZ; 18-31 are illegal.
REQ-007 rd, rs, rt  input  3 each  destination, source A and source B register numbers.
REQ-008 imm  input  6  immediate value or branch offset.
REQ-009 imem_we  output  1  instruction-memory write strobe.
REQ-010 imem_addr  output  ADDR_W  instruction-memory write address.
REQ-011 imem_wdata  output  16  encoded instruction word.
REQ-012 count  output  ADDR_W+1  number of words written since the last start.
REQ-013 busy, done, full, err  output  1 each  status flags.

Function
REQ-014 The FSM states are IDLE, LOAD, PAD (present only with the macro) and DONE.
REQ-015 A start in IDLE or DONE moves the FSM to LOAD, clears count, done, full and err; start is ignored in LOAD and PAD.
REQ-016 in_ready is 1 only in LOAD, when count < depth and no HALT has been accepted.
REQ-017 Encoding, with unused fields zero:
- NOP = 16'h0000; HALT = 16'h0001.
- LB, ADDI, ANDI, ORI = {4'b0010/0101/0110/0111, rs, rd, imm}.
- SB = {4'b0100, rs, rt, imm}.
- R-type = {4'b1111, rs, rt, rd, funct}, with funct 000 ADD, 001 SUB, 010 SRA, 011 SRL, 100 SLL, 101 AND, 110 OR.
- SRA, SRL and SLL place 3'b000 in [8:6].
- BEQ, BNE = {4'b1000/1001, rs, rt, imm}.
- BGEZ, BLTZ = {4'b1010/1011, rs, 3'b000, imm}.
REQ-018 Latency: a legal transfer at edge N produces imem_we=1 for exactly one cycle after edge N, with imem_addr = count before the increment and imem_wdata = the encoded word; count increments at edge N+1.
REQ-019 Back-to-back transfers sustain one write per cycle.
REQ-020 An illegal op transfer sets err (sticky until the next start or reset), produces no write and leaves count unchanged; loading continues.
REQ-021 After the write of HALT, the FSM enters DONE (or PAD when the macro is defined).
REQ-022 When count reaches depth without a HALT, the FSM sets full=1 and enters DONE.
REQ-023 done is 1 exactly in DONE; busy is 1 in LOAD and PAD.
REQ-024 imem_we is never 1 in IDLE or DONE, except for the write completing the transfer that caused the move to DONE.

Reset
REQ-025 When rst=1 at an edge, the FSM goes to IDLE and sets imem_we=0, imem_addr=0, imem_wdata=0, count=0 and busy, done, full, err = 0; in_ready=0.
REQ-026 A reset during LOAD or PAD cancels any pending write the same cycle.

Configuration
REQ-027 With macro ENC_HALT_PAD_EN defined, after the HALT write the block writes 16'h0000 at every remaining address up to depth-1, one per cycle in PAD, then enters DONE with count = depth.
REQ-028 Without ENC_HALT_PAD_EN, the FSM goes from the HALT write directly to DONE; the PAD state does not exist.

Verification
REQ-029 ADDR_W=8; start; ADD with rs=1, rt=2, rd=3 -> one cycle later imem_we=1, addr 0, wdata 16'hF298, then count=1.
REQ-030 LB with rs=5, rd=2, imm=6'h3F, then BLTZ with rs=4, imm=6'h05, back-to-back -> addr 0 gets 16'h2ABF and addr 1 gets 16'hB805 on consecutive cycles.
REQ-031 op=20 in the middle of a stream -> err=1, no write, the next legal word goes to the next sequential address.
REQ-032 HALT as the fourth word ->
- addr 3 gets 16'h0001.
- Without the macro: done=1 the next cycle and count=4.
- With the macro: addrs 4..255 get 16'h0000, then done=1 and count=256.
REQ-033 256 NOPs with no HALT -> full=1, done=1, in_ready=0; a 257th in_valid is not accepted.
REQ-034 rst asserted during the cycle after a transfer -> no write, all outputs 0; a new start restarts at addr 0.

Source files
------------

// File: rtl/inst_encoder.sv
// ============================================================================
// Module   : inst_encoder
// Purpose  : Accepts decoded instruction fields over a valid/ready handshake,
//            encodes each into a 16-bit instruction word and writes it
//            sequentially into an instruction memory.
//            Loading stops on HALT or when the memory is full.
//            Illegal opcodes raise a sticky error flag and are dropped.
// Config   : `define ENC_HALT_PAD_EN
//            After the HALT word, every remaining address is filled with NOP
//            (16'h0000), one word per cycle, before DONE is entered.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start_i         - one-cycle pulse that begins a program load
//            in_valid_i      - instruction fields valid
//            in_ready_o      - encoder ready for the next instruction
//            op_i, rd_i, rs_i, rt_i, imm_i - instruction fields
//            imem_we_o, imem_addr_o, imem_wdata_o - memory write port
//            count_o         - words written since the last start
//            busy_o, done_o, full_o, err_o     - status flags
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [4:0]        op_i,
  input  logic [2:0]        rd_i,
  input  logic [2:0]        rs_i,
  input  logic [2:0]        rt_i,
  input  logic [5:0]        imm_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [15:0]       imem_wdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              full_o,
  output logic              err_o
);

  // Address of the last memory word, and a width-matched increment.
  localparam logic [ADDR_W:0] c_LAST = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] c_ONE  = {{ADDR_W{1'b0}}, 1'b1};

`ifdef ENC_HALT_PAD_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_PAD  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t              state_q;
  // wptr_q counts accepted words and leads count_q by one cycle, because
  // count_q only advances once the corresponding write has been presented.
  logic [ADDR_W:0]     wptr_q;
  logic [ADDR_W:0]     count_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [15:0]         wdata_q;
  logic                ready_q;
  logic                busy_q;
  logic                done_q;
  logic                full_q;
  logic                err_q;

  logic [15:0]         wdata_d;
  logic                legal_d;
  logic                halt_d;
  logic                xfer_d;

  assign xfer_d = in_valid_i & ready_q;

  // --------------------------------------------------------------------------
  // Instruction encoder; fields not used by a format are forced to zero.
  // --------------------------------------------------------------------------
  always_comb begin
    wdata_d = 16'h0000;
    legal_d = 1'b1;
    halt_d  = 1'b0;
    case (op_i)
      5'd0:  wdata_d = 16'h0000;                                  // NOP
      5'd1:  begin                                                // HALT
        wdata_d = 16'h0001;
        halt_d  = 1'b1;
      end
      5'd2:  wdata_d = {4'b0010, rs_i, rd_i, imm_i};              // LB
      5'd3:  wdata_d = {4'b0100, rs_i, rt_i, imm_i};              // SB
      5'd4:  wdata_d = {4'b0101, rs_i, rd_i, imm_i};              // ADDI
      5'd5:  wdata_d = {4'b0110, rs_i, rd_i, imm_i};              // ANDI
      5'd6:  wdata_d = {4'b0111, rs_i, rd_i, imm_i};              // ORI
      5'd7:  wdata_d = {4'b1111, rs_i, rt_i, rd_i, 3'b000};       // ADD
      5'd8:  wdata_d = {4'b1111, rs_i, rt_i, rd_i, 3'b001};       // SUB
      // Shifts carry no second source register: the rt slot is zero.
      5'd9:  wdata_d = {4'b1111, rs_i, 3'b000, rd_i, 3'b010};     // SRA
      5'd10: wdata_d = {4'b1111, rs_i, 3'b000, rd_i, 3'b011};     // SRL
      5'd11: wdata_d = {4'b1111, rs_i, 3'b000, rd_i, 3'b100};     // SLL
      5'd12: wdata_d = {4'b1111, rs_i, rt_i, rd_i, 3'b101};       // AND
      5'd13: wdata_d = {4'b1111, rs_i, rt_i, rd_i, 3'b110};       // OR
      5'd14: wdata_d = {4'b1000, rs_i, rt_i, imm_i};              // BEQ
      5'd15: wdata_d = {4'b1001, rs_i, rt_i, imm_i};              // BNE
      5'd16: wdata_d = {4'b1010, rs_i, 3'b000, imm_i};            // BGEZ
      5'd17: wdata_d = {4'b1011, rs_i, 3'b000, imm_i};            // BLTZ
      default: legal_d = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      // The word presented last cycle is now committed.
      if (we_q) begin
        count_q <= count_q + c_ONE;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q <= S_LOAD;
            wptr_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end

        S_LOAD: begin
          if (xfer_d) begin
            if (!legal_d) begin
              err_q <= 1'b1;
            end else begin
              we_q    <= 1'b1;
              addr_q  <= wptr_q[ADDR_W-1:0];
              wdata_q <= wdata_d;
              wptr_q  <= wptr_q + c_ONE;
              if (halt_d) begin
                ready_q <= 1'b0;
`ifdef ENC_HALT_PAD_EN
                if (wptr_q == c_LAST) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= S_PAD;
                end
`else
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
`endif
              end else if (wptr_q == c_LAST) begin
                // Memory exhausted without a HALT.
                state_q <= S_DONE;
                ready_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                full_q  <= 1'b1;
              end
            end
          end
        end

`ifdef ENC_HALT_PAD_EN
        S_PAD: begin
          we_q    <= 1'b1;
          addr_q  <= wptr_q[ADDR_W-1:0];
          wdata_q <= 16'h0000;
          wptr_q  <= wptr_q + c_ONE;
          if (wptr_q == c_LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
`endif

        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o   = ready_q;
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign count_o      = count_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign full_o       = full_q;
  assign err_o        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
// ============================================================================
// Module   : tb_inst_encoder
// Purpose  : Directed self-checking bench for inst_encoder (ADDR_W = 8).
//            Works for both the default build and ENC_HALT_PAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [2:0]  rd, rs, rt;
  logic [5:0]  imm;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic [8:0]  count;
  logic        busy, done, full, err;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]  op;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [5:0]  imm;
    logic [15:0] w;
  } vec_t;

  vec_t tv [13];

  inst_encoder #(.ADDR_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .op_i         (op),
    .rd_i         (rd),
    .rs_i         (rs),
    .rt_i         (rt),
    .imm_i        (imm),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .count_o      (count),
    .busy_o       (busy),
    .done_o       (done),
    .full_o       (full),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic [4:0] o, input logic [2:0] s, input logic [2:0] t,
                     input logic [2:0] d, input logic [5:0] i);
    in_valid = 1'b1;
    op = o; rs = s; rt = t; rd = d; imm = i;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    {31'd0, imem_we}, 32'd0);
    chk({tag, "_addr"},  {24'd0, imem_addr}, 32'd0);
    chk({tag, "_wdata"}, {16'd0, imem_wdata}, 32'd0);
    chk({tag, "_count"}, {23'd0, count}, 32'd0);
    chk({tag, "_flags"}, {27'd0, busy, done, full, err, in_ready}, 32'd0);
  endtask

  initial begin
    tv[0]  = '{5'd3,  3'd3, 3'd6, 3'd0, 6'h15, 16'h4795}; // SB
    tv[1]  = '{5'd8,  3'd7, 3'd1, 3'd5, 6'h2A, 16'hFE69}; // SUB
    tv[2]  = '{5'd9,  3'd2, 3'd5, 3'd4, 6'h00, 16'hF422}; // SRA
    tv[3]  = '{5'd10, 3'd6, 3'd7, 3'd1, 6'h00, 16'hFC0B}; // SRL
    tv[4]  = '{5'd11, 3'd1, 3'd3, 3'd7, 6'h00, 16'hF23C}; // SLL
    tv[5]  = '{5'd12, 3'd4, 3'd5, 3'd6, 6'h00, 16'hF975}; // AND
    tv[6]  = '{5'd13, 3'd0, 3'd7, 3'd2, 6'h00, 16'hF1D6}; // OR
    tv[7]  = '{5'd5,  3'd2, 3'd7, 3'd3, 6'h2A, 16'h64EA}; // ANDI
    tv[8]  = '{5'd6,  3'd5, 3'd0, 3'd1, 6'h01, 16'h7A41}; // ORI
    tv[9]  = '{5'd14, 3'd1, 3'd2, 3'd7, 6'h3E, 16'h82BE}; // BEQ
    tv[10] = '{5'd15, 3'd7, 3'd7, 3'd0, 6'h00, 16'h9FC0}; // BNE
    tv[11] = '{5'd16, 3'd3, 3'd5, 3'd0, 6'h10, 16'hA610}; // BGEZ
    tv[12] = '{5'd0,  3'd7, 3'd7, 3'd7, 6'h3F, 16'h0000}; // NOP

    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    op = '0; rs = '0; rt = '0; rd = '0; imm = '0;
    step(); step();
    chk_all_zero("reset");

    // IDLE ignores in_valid.
    rst = 1'b0;
    drv(5'd7, 3'd1, 3'd2, 3'd3, 6'h00);
    step();
    in_valid = 1'b0;
    chk("idle_we", {31'd0, imem_we}, 32'd0);
    chk("idle_ready", {31'd0, in_ready}, 32'd0);

    // Single ADD.
    start = 1'b1; step(); start = 1'b0;
    chk("load_flags", {27'd0, busy, done, full, err, in_ready}, 32'h11);
    chk("load_count", {23'd0, count}, 32'd0);
    drv(5'd7, 3'd1, 3'd2, 3'd3, 6'h00);
    step();
    in_valid = 1'b0;
    chk("add_we", {31'd0, imem_we}, 32'd1);
    chk("add_addr", {24'd0, imem_addr}, 32'd0);
    chk("add_wdata", {16'd0, imem_wdata}, 32'hF298);
    chk("add_count_pre", {23'd0, count}, 32'd0);
    step();
    chk("add_we_off", {31'd0, imem_we}, 32'd0);
    chk("add_count", {23'd0, count}, 32'd1);

    // Reset in the cycle after a transfer.
    drv(5'd4, 3'd1, 3'd0, 3'd2, 6'h03);
    step();
    in_valid = 1'b0;
    chk("pre_rst_addr", {23'd0, imem_we, imem_addr}, 32'h101);
    rst = 1'b1; step(); rst = 1'b0;
    chk_all_zero("rst_mid");

    // Restart: LB, BLTZ back-to-back, illegal op, ADDI, HALT.
    start = 1'b1; step(); start = 1'b0;
    drv(5'd2, 3'd5, 3'd0, 3'd2, 6'h3F);
    step();
    chk("lb_addr", {23'd0, imem_we, imem_addr}, 32'h100);
    chk("lb_wdata", {16'd0, imem_wdata}, 32'h2ABF);
    drv(5'd17, 3'd4, 3'd0, 3'd0, 6'h05);
    step();
    chk("bltz_addr", {23'd0, imem_we, imem_addr}, 32'h101);
    chk("bltz_wdata", {16'd0, imem_wdata}, 32'hB805);
    drv(5'd20, 3'd1, 3'd1, 3'd1, 6'h01);
    step();
    chk("ill_we", {31'd0, imem_we}, 32'd0);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_count", {23'd0, count}, 32'd2);
    drv(5'd4, 3'd1, 3'd0, 3'd2, 6'h03);
    step();
    chk("addi_addr", {23'd0, imem_we, imem_addr}, 32'h102);
    chk("addi_wdata", {16'd0, imem_wdata}, 32'h5283);
    drv(5'd1, 3'd0, 3'd0, 3'd0, 6'h00);
    step();
    in_valid = 1'b0;
    chk("halt_addr", {23'd0, imem_we, imem_addr}, 32'h103);
    chk("halt_wdata", {16'd0, imem_wdata}, 32'h0001);
    chk("halt_ready", {31'd0, in_ready}, 32'd0);
`ifdef ENC_HALT_PAD_EN
    for (int k = 4; k < 256; k++) begin
      step();
      chk("pad_addr", {23'd0, imem_we, imem_addr}, 32'h100 | k);
      chk("pad_wdata", {16'd0, imem_wdata}, 32'h0000);
    end
    chk("pad_done", {31'd0, done}, 32'd1);
    step();
    chk("pad_count", {23'd0, count}, 32'd256);
    chk("pad_flags", {27'd0, busy, done, full, err, in_ready}, 32'h0A);
    chk("pad_we_off", {31'd0, imem_we}, 32'd0);
`else
    step();
    chk("halt_count", {23'd0, count}, 32'd4);
    chk("halt_flags", {27'd0, busy, done, full, err, in_ready}, 32'h0A);
    chk("halt_we_off", {31'd0, imem_we}, 32'd0);
`endif

    // Encoding table, streamed back-to-back; a start mid-stream is ignored.
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      drv(tv[i].op, tv[i].rs, tv[i].rt, tv[i].rd, tv[i].imm);
      if (i == 5) start = 1'b1;
      step();
      start = 1'b0;
      chk("tab_addr", {23'd0, imem_we, imem_addr}, 32'h100 | i);
      chk("tab_wdata", {16'd0, imem_wdata}, {16'd0, tv[i].w});
    end
    in_valid = 1'b0;
    step();
    chk("tab_count", {23'd0, count}, 32'd13);
    chk("tab_busy", {27'd0, busy, done, full, err, in_ready}, 32'h11);

    // Fill all 256 words with NOPs, no HALT.
    rst = 1'b1; step(); rst = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    drv(5'd0, 3'd0, 3'd0, 3'd0, 6'h00);
    for (int i = 0; i < 256; i++) begin
      step();
      chk("nop_addr", {23'd0, imem_we, imem_addr}, 32'h100 | i);
    end
    chk("full_flags", {27'd0, busy, done, full, err, in_ready}, 32'h0C);
    step();
    chk("full_257_we", {31'd0, imem_we}, 32'd0);
    chk("full_count", {23'd0, count}, 32'd256);
    step();
    in_valid = 1'b0;
    chk("full_257_we2", {31'd0, imem_we}, 32'd0);
    chk("full_count2", {23'd0, count}, 32'd256);
    chk("full_flags2", {27'd0, busy, done, full, err, in_ready}, 32'h0C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
